// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - Non-blocking direct-mapped dcache controller with load-miss MSHRs
// Define DCACHE_STATS_EN to add saturating hit/miss/reject counters.
module dcache_ctrl #(
  parameter int NUM_SETS = 16,
  parameter int NUM_MSHR = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_is_store,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic [63:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_accepted,
  output logic             resp_valid,
  output logic             resp_is_store,
  output logic [TAG_W-1:0] resp_tag,
  output logic [63:0]      resp_data,
  output logic [1:0]       mem_command,
  output logic [31:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [3:0]       mem_resp_tag,
  input  logic [3:0]       mem_data_tag,
  input  logic [63:0]      mem_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_rejects
`endif
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int CT_W  = 29 - IDX_W;
  localparam int MI_W  = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam logic [1:0] CMD_NONE = 2'd0, CMD_LOAD = 2'd1, CMD_STORE = 2'd2;

  typedef enum logic [1:0] {M_INVALID, M_WAIT_ISSUE, M_WAIT_DATA} mshr_state_t;

  logic [NUM_SETS-1:0] line_valid;
  logic [CT_W-1:0]     line_tag  [NUM_SETS];
  logic [63:0]         line_data [NUM_SETS];

  mshr_state_t         m_state      [NUM_MSHR];
  mshr_state_t         m_state_next [NUM_MSHR];
  logic [28:0]         m_blk        [NUM_MSHR];
  logic [TAG_W-1:0]    m_rtag       [NUM_MSHR];
  logic [3:0]          m_mtag       [NUM_MSHR];
  // older[j][i] set means entry j was allocated before entry i
  logic [NUM_MSHR-1:0] older        [NUM_MSHR];

  logic [IDX_W-1:0] req_idx;
  logic [CT_W-1:0]  req_ctag;
  logic [28:0]      req_blk, fill_blk;
  logic             line_hit, blk_pending, mshr_free, fill, issue, cand;
  logic [MI_W-1:0]  free_idx, fill_idx, issue_idx;
  logic [7:0]       size_mask, bmask8;
  logic [63:0]      byte_mask, shifted, merged;
  logic             store_elig, store_acc, load_ok, load_hit_acc, alloc, issue_go;

  assign req_idx  = req_addr[IDX_W+2:3];
  assign req_ctag = req_addr[31:IDX_W+3];
  assign req_blk  = req_addr[31:3];
  assign fill_blk = m_blk[fill_idx];

  always_comb begin
    blk_pending = 1'b0;
    mshr_free   = 1'b0;
    free_idx    = '0;
    fill        = 1'b0;
    fill_idx    = '0;
    issue       = 1'b0;
    issue_idx   = '0;
    cand        = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (m_state[i] == M_INVALID) begin
        mshr_free = 1'b1;
        free_idx  = MI_W'(i);
      end else if (m_blk[i] == req_blk) begin
        blk_pending = 1'b1;
      end
      if (m_state[i] == M_WAIT_DATA && mem_data_tag != 4'd0 && m_mtag[i] == mem_data_tag) begin
        fill     = 1'b1;
        fill_idx = MI_W'(i);
      end
    end
    for (int i = 0; i < NUM_MSHR; i++) begin
      cand = (m_state[i] == M_WAIT_ISSUE);
      for (int j = 0; j < NUM_MSHR; j++)
        if (m_state[j] == M_WAIT_ISSUE && older[j][i]) cand = 1'b0;
      if (cand && !issue) begin
        issue     = 1'b1;
        issue_idx = MI_W'(i);
      end
    end

    line_hit = line_valid[req_idx] && (line_tag[req_idx] == req_ctag);
    case (req_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    bmask8 = size_mask << req_addr[2:0];
    byte_mask = '0;
    for (int b = 0; b < 8; b++) byte_mask[b*8 +: 8] = {8{bmask8[b]}};
    shifted = req_wdata << {req_addr[2:0], 3'b000};
    merged  = ((line_hit ? line_data[req_idx] : 64'd0) & ~byte_mask) | (shifted & byte_mask);

    // A store only claims the memory port once nothing else can veto it
    store_elig   = req_valid && req_is_store && !fill && !blk_pending;
    store_acc    = store_elig && (mem_resp_tag != 4'd0);
    load_ok      = req_valid && !req_is_store && !fill && (line_hit || (mshr_free && !blk_pending));
    load_hit_acc = load_ok && line_hit;
    alloc        = load_ok && !line_hit;
    req_accepted = load_ok || store_acc;

    mem_command = CMD_NONE;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (store_elig) begin
      mem_command = CMD_STORE;
      mem_addr    = {req_blk, 3'b000};
      mem_wdata   = merged;
    end else if (issue) begin
      mem_command = CMD_LOAD;
      mem_addr    = {m_blk[issue_idx], 3'b000};
    end
    issue_go = !store_elig && issue && (mem_resp_tag != 4'd0);

    for (int i = 0; i < NUM_MSHR; i++) m_state_next[i] = m_state[i];
    if (fill)     m_state_next[fill_idx]  = M_INVALID;
    if (issue_go) m_state_next[issue_idx] = M_WAIT_DATA;
    if (alloc)    m_state_next[free_idx]  = M_WAIT_ISSUE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) m_state[i] <= M_INVALID;
      line_valid    <= '0;
      resp_valid    <= 1'b0;
      resp_is_store <= 1'b0;
      resp_tag      <= '0;
      resp_data     <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) m_state[i] <= m_state_next[i];
      if (fill) line_valid[fill_blk[IDX_W-1:0]] <= 1'b1;
      resp_valid    <= 1'b0;
      resp_is_store <= 1'b0;
      resp_tag      <= '0;
      resp_data     <= '0;
      if (fill) begin
        resp_valid <= 1'b1;
        resp_tag   <= m_rtag[fill_idx];
        resp_data  <= mem_data;
      end else if (load_hit_acc) begin
        resp_valid <= 1'b1;
        resp_tag   <= req_tag;
        resp_data  <= line_data[req_idx];
      end else if (store_acc) begin
        resp_valid    <= 1'b1;
        resp_is_store <= 1'b1;
        resp_tag      <= req_tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      line_tag[fill_blk[IDX_W-1:0]]  <= fill_blk[28:IDX_W];
      line_data[fill_blk[IDX_W-1:0]] <= mem_data;
    end
    if (store_acc && line_hit) line_data[req_idx] <= merged;
    if (alloc) begin
      m_blk[free_idx]  <= req_blk;
      m_rtag[free_idx] <= req_tag;
      for (int j = 0; j < NUM_MSHR; j++) begin
        older[free_idx][j] <= 1'b0;
        if (MI_W'(j) != free_idx) older[j][free_idx] <= 1'b1;
      end
    end
    if (issue_go) m_mtag[issue_idx] <= mem_resp_tag;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits    <= '0;
      stat_misses  <= '0;
      stat_rejects <= '0;
    end else begin
      if (load_hit_acc && stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      if (alloc && stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      if (req_valid && !req_accepted && stat_rejects != 32'hFFFF_FFFF)
        stat_rejects <= stat_rejects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - Directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_is_store, req_accepted;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_is_store;
  logic [4:0]  resp_tag;
  logic [63:0] resp_data;
  logic [1:0]  mem_command;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_resp_tag, mem_data_tag;
  logic [63:0] mem_data;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dcache_ctrl #(.NUM_SETS(16), .NUM_MSHR(4), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_tag(req_tag),
    .req_accepted(req_accepted),
    .resp_valid(resp_valid), .resp_is_store(resp_is_store), .resp_tag(resp_tag),
    .resp_data(resp_data),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_tag(mem_resp_tag), .mem_data_tag(mem_data_tag), .mem_data(mem_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic st, input logic [31:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input logic [4:0] tg);
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_size = sz; req_wdata = wd; req_tag = tg;
  endtask

  task automatic no_req();
    req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; req_tag = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; no_req(); mem_resp_tag = 0; mem_data_tag = 0; mem_data = 0;
    tick(); tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
    checks++; if (resp_tag !== 5'd0) begin errors++; $display("FAIL rst_resp_tag got=%0h exp=0", resp_tag); end
    checks++; if (resp_data !== 64'd0) begin errors++; $display("FAIL rst_resp_data got=%0h exp=0", resp_data); end
    checks++; if (resp_is_store !== 1'b0) begin errors++; $display("FAIL rst_resp_is_store got=%0h exp=0", resp_is_store); end
    checks++; if (mem_command !== 2'd0) begin errors++; $display("FAIL rst_mem_command got=%0h exp=0", mem_command); end
    checks++; if (req_accepted !== 1'b0) begin errors++; $display("FAIL rst_req_accepted got=%0h exp=0", req_accepted); end
    reset = 1'b0;
  endtask

  task automatic test_load_miss_refill();
    set_req(0, 32'h100, 2'd3, 64'd0, 5'd1); #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t1_miss_acc got=%0h exp=1", req_accepted); end
    checks++; if (mem_command !== 2'd0) begin errors++; $display("FAIL t1_no_same_cycle_issue got=%0h exp=0", mem_command); end
    tick(); no_req(); mem_resp_tag = 4'd3; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL t1_miss_no_resp got=%0h exp=0", resp_valid); end
    checks++; if (mem_command !== 2'd1 || mem_addr !== 32'h100) begin errors++; $display("FAIL t1_issue got=%0h/%0h exp=1/100", mem_command, mem_addr); end
    tick(); mem_resp_tag = 4'd0; #1;
    checks++; if (mem_command !== 2'd0) begin errors++; $display("FAIL t1_wait_data_cmd got=%0h exp=0", mem_command); end
    tick(); tick();
    mem_data_tag = 4'd3; mem_data = 64'h1122334455667788;
    tick(); mem_data_tag = 4'd0;
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd1 || resp_is_store !== 1'b0) begin errors++; $display("FAIL t1_fill_resp got=%0h/%0h/%0h exp=1/1/0", resp_valid, resp_tag, resp_is_store); end
    checks++; if (resp_data !== 64'h1122334455667788) begin errors++; $display("FAIL t1_fill_data got=%0h exp=1122334455667788", resp_data); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL t1_resp_pulse got=%0h exp=0", resp_valid); end
    set_req(0, 32'h104, 2'd2, 64'd0, 5'd2); #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t1_hit_acc got=%0h exp=1", req_accepted); end
    tick(); no_req();
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd2 || resp_data !== 64'h1122334455667788) begin errors++; $display("FAIL t1_hit_resp got=%0h/%0h/%0h exp=1/2/1122334455667788", resp_valid, resp_tag, resp_data); end
  endtask

  task automatic test_store();
    set_req(1, 32'h104, 2'd2, 64'hDEADBEEF, 5'd3); mem_resp_tag = 4'd5; #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t2_st_acc got=%0h exp=1", req_accepted); end
    checks++; if (mem_command !== 2'd2 || mem_addr !== 32'h100) begin errors++; $display("FAIL t2_st_cmd got=%0h/%0h exp=2/100", mem_command, mem_addr); end
    checks++; if (mem_wdata !== 64'hDEADBEEF55667788) begin errors++; $display("FAIL t2_st_wdata got=%0h exp=deadbeef55667788", mem_wdata); end
    tick(); no_req(); mem_resp_tag = 4'd0;
    checks++; if (resp_valid !== 1'b1 || resp_is_store !== 1'b1 || resp_tag !== 5'd3 || resp_data !== 64'd0) begin errors++; $display("FAIL t2_st_resp got=%0h/%0h/%0h/%0h exp=1/1/3/0", resp_valid, resp_is_store, resp_tag, resp_data); end
    set_req(1, 32'h305, 2'd0, 64'hAB, 5'd6); #1;
    checks++; if (req_accepted !== 1'b0 || mem_command !== 2'd2) begin errors++; $display("FAIL t2_st_mem_reject got=%0h/%0h exp=0/2", req_accepted, mem_command); end
    checks++; if (mem_wdata !== 64'h0000AB0000000000) begin errors++; $display("FAIL t2_st_miss_wdata got=%0h exp=0000ab0000000000", mem_wdata); end
    mem_resp_tag = 4'd6; #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t2_st_miss_acc got=%0h exp=1", req_accepted); end
    tick(); no_req(); mem_resp_tag = 4'd0;
    checks++; if (resp_valid !== 1'b1 || resp_is_store !== 1'b1 || resp_tag !== 5'd6) begin errors++; $display("FAIL t2_st_miss_resp got=%0h/%0h/%0h exp=1/1/6", resp_valid, resp_is_store, resp_tag); end
    set_req(0, 32'h100, 2'd3, 64'd0, 5'd4); #1;
    tick(); no_req();
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd4 || resp_data !== 64'hDEADBEEF55667788) begin errors++; $display("FAIL t2_merged_load got=%0h/%0h/%0h exp=1/4/deadbeef55667788", resp_valid, resp_tag, resp_data); end
  endtask

  task automatic test_mshr_full();
    logic [31:0] addrs [5];
    logic [3:0]  ftag  [4];
    logic [4:0]  rtag  [4];
    addrs = '{32'h400, 32'h408, 32'h410, 32'h418, 32'h420};
    ftag  = '{4'd2, 4'd4, 4'd5, 4'd6};
    rtag  = '{5'd10, 5'd12, 5'd13, 5'd14};
    for (int i = 0; i < 5; i++) begin
      set_req(0, addrs[i], 2'd3, 64'd0, 5'(10 + i)); mem_resp_tag = 4'(i + 1); #1;
      checks++; if (req_accepted !== (i < 4)) begin errors++; $display("FAIL t3_acc_%0d got=%0h exp=%0h", i, req_accepted, (i < 4)); end
      if (i > 0) begin
        checks++; if (mem_command !== 2'd1 || mem_addr !== addrs[i-1]) begin errors++; $display("FAIL t3_issue_%0d got=%0h/%0h exp=1/%0h", i, mem_command, mem_addr, addrs[i-1]); end
      end
      tick();
    end
    mem_resp_tag = 4'd0; mem_data_tag = 4'd3; mem_data = 64'h0123456789ABCDEF; #1;
    checks++; if (req_accepted !== 1'b0) begin errors++; $display("FAIL t3_fill_blocks_req got=%0h exp=0", req_accepted); end
    tick(); mem_data_tag = 4'd0;
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd11 || resp_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL t3_fill_resp got=%0h/%0h/%0h exp=1/b/123456789abcdef", resp_valid, resp_tag, resp_data); end
    #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t3_retry_acc got=%0h exp=1", req_accepted); end
    tick(); no_req(); mem_resp_tag = 4'd6; #1;
    checks++; if (mem_command !== 2'd1 || mem_addr !== 32'h420) begin errors++; $display("FAIL t3_retry_issue got=%0h/%0h exp=1/420", mem_command, mem_addr); end
    tick(); mem_resp_tag = 4'd0;
    for (int i = 0; i < 4; i++) begin
      mem_data_tag = ftag[i]; mem_data = 64'h1000 + 64'(i);
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_tag !== rtag[i]) begin errors++; $display("FAIL t3_drain_%0d got=%0h/%0h exp=1/%0h", i, resp_valid, resp_tag, rtag[i]); end
    end
    mem_data_tag = 4'd0;
  endtask

  task automatic test_same_block();
    set_req(0, 32'h200, 2'd3, 64'd0, 5'd15); #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t4_miss_acc got=%0h exp=1", req_accepted); end
    tick(); no_req(); mem_resp_tag = 4'd7; #1;
    tick();
    set_req(1, 32'h208, 2'd3, 64'h0102030405060708, 5'd16); mem_resp_tag = 4'd8; #1;
    checks++; if (req_accepted !== 1'b1 || mem_addr !== 32'h208 || mem_wdata !== 64'h0102030405060708) begin errors++; $display("FAIL t4_other_blk got=%0h/%0h/%0h exp=1/208/102030405060708", req_accepted, mem_addr, mem_wdata); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_is_store !== 1'b1 || resp_tag !== 5'd16) begin errors++; $display("FAIL t4_other_resp got=%0h/%0h/%0h exp=1/1/10", resp_valid, resp_is_store, resp_tag); end
    set_req(0, 32'h204, 2'd2, 64'd0, 5'd17); #1;
    checks++; if (req_accepted !== 1'b0 || mem_command !== 2'd0) begin errors++; $display("FAIL t4_ld_same_blk got=%0h/%0h exp=0/0", req_accepted, mem_command); end
    set_req(1, 32'h204, 2'd2, 64'h55, 5'd17); #1;
    checks++; if (req_accepted !== 1'b0 || mem_command !== 2'd0) begin errors++; $display("FAIL t4_st_same_blk got=%0h/%0h exp=0/0", req_accepted, mem_command); end
    tick(); no_req(); mem_resp_tag = 4'd0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL t4_reject_no_resp got=%0h exp=0", resp_valid); end
    mem_data_tag = 4'd7; mem_data = 64'hAAAABBBBCCCCDDDD;
    tick(); mem_data_tag = 4'd0;
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd15) begin errors++; $display("FAIL t4_fill_resp got=%0h/%0h exp=1/f", resp_valid, resp_tag); end
    set_req(0, 32'h204, 2'd2, 64'd0, 5'd17); #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t4_after_fill_acc got=%0h exp=1", req_accepted); end
    tick(); no_req();
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd17 || resp_data !== 64'hAAAABBBBCCCCDDDD) begin errors++; $display("FAIL t4_hit_resp got=%0h/%0h/%0h exp=1/11/aaaabbbbccccdddd", resp_valid, resp_tag, resp_data); end
  endtask

  task automatic test_fill_vs_hit();
    set_req(0, 32'h600, 2'd3, 64'd0, 5'd18); #1;
    tick(); no_req(); mem_resp_tag = 4'd9; #1;
    checks++; if (mem_command !== 2'd1 || mem_addr !== 32'h600) begin errors++; $display("FAIL t5_issue got=%0h/%0h exp=1/600", mem_command, mem_addr); end
    tick(); mem_resp_tag = 4'd0;
    set_req(0, 32'h408, 2'd3, 64'd0, 5'd19); mem_data_tag = 4'd9; mem_data = 64'h5555666677778888; #1;
    checks++; if (req_accepted !== 1'b0) begin errors++; $display("FAIL t5_hit_blocked got=%0h exp=0", req_accepted); end
    tick(); mem_data_tag = 4'd0;
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd18 || resp_data !== 64'h5555666677778888) begin errors++; $display("FAIL t5_fill_resp got=%0h/%0h/%0h exp=1/12/5555666677778888", resp_valid, resp_tag, resp_data); end
    #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t5_retry_acc got=%0h exp=1", req_accepted); end
    tick(); no_req();
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd19 || resp_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL t5_hit_resp got=%0h/%0h/%0h exp=1/13/123456789abcdef", resp_valid, resp_tag, resp_data); end
  endtask

  task automatic test_retry_and_reset();
    set_req(0, 32'h700, 2'd3, 64'd0, 5'd20); #1;
    tick(); no_req(); mem_resp_tag = 4'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mem_command !== 2'd1 || mem_addr !== 32'h700) begin errors++; $display("FAIL t6_redrive_%0d got=%0h/%0h exp=1/700", k, mem_command, mem_addr); end
      tick();
    end
    mem_resp_tag = 4'hA; #1;
    checks++; if (mem_command !== 2'd1) begin errors++; $display("FAIL t6_final_issue got=%0h exp=1", mem_command); end
    tick(); mem_resp_tag = 4'd0; #1;
    checks++; if (mem_command !== 2'd0 || resp_valid !== 1'b0) begin errors++; $display("FAIL t6_wait_data got=%0h/%0h exp=0/0", mem_command, resp_valid); end
    reset = 1'b1;
    tick(); reset = 1'b0;
    mem_data_tag = 4'hA; mem_data = 64'hFEEDFACECAFEF00D;
    tick(); mem_data_tag = 4'd0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL t6_late_refill got=%0h exp=0", resp_valid); end
    set_req(0, 32'h600, 2'd3, 64'd0, 5'd21); #1;
    checks++; if (req_accepted !== 1'b1) begin errors++; $display("FAIL t6_post_rst_acc got=%0h exp=1", req_accepted); end
    tick(); no_req(); #1;
    checks++; if (resp_valid !== 1'b0 || mem_command !== 2'd1 || mem_addr !== 32'h600) begin errors++; $display("FAIL t6_valid_cleared got=%0h/%0h/%0h exp=0/1/600", resp_valid, mem_command, mem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_miss_refill();
    test_store();
    test_mshr_full();
    test_same_block();
    test_fill_vs_hit();
    test_retry_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Non-blocking direct-mapped data cache controller and responder for the store queue's single-request dcache port. It accepts one load or store request per cycle and serves load hits from the tag/data array. Load misses are tracked in MSHRs, and each request completes with exactly one registered response carrying the requester's tag. It sits between the LSQ and the tagged memory bus: stores write-through, load misses refill.

Parameters:
NUM_SETS, 16, direct-mapped sets (power of 2); one 8-byte block per set
NUM_MSHR, 4, outstanding load-miss entries
TAG_W, 5, requester tag width (LSQ index)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present this cycle
req_is_store  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  0=byte,1=half,2=word,3=double
req_wdata  in  64  store data, right-justified
req_tag  in  TAG_W  requester tag, echoed in response
req_accepted  out  1  combinational; request taken this cycle
resp_valid  out  1  registered response valid
resp_is_store  out  1  response belongs to a store
resp_tag  out  TAG_W  echoed tag
resp_data  out  64  full 8-byte block for loads; 0 for stores
mem_command  out  2  0=NONE,1=LOAD,2=STORE
mem_addr  out  32  block-aligned address (bits[2:0]=0)
mem_wdata  out  64  store block
mem_resp_tag  in  4  combinational accept tag; 0=rejected
mem_data_tag  in  4  refill tag; 0=no data
mem_data  in  64  refill data

Behaviour:
- Reset: all valid bits and MSHRs cleared; resp_valid=0, resp_tag=0, resp_data=0, resp_is_store=0, mem_command=NONE, req_accepted=0.
- Address split: offset[2:0], index[log2(NUM_SETS)+2:3], tag = remaining upper bits.
- Fill cycle: any cycle where mem_data_tag!=0 matches a WAIT_DATA MSHR.
  - Block written to its set, valid set, MSHR freed.
  - Next cycle: resp_valid=1, resp_is_store=0, MSHR's req_tag, refill data.
  - req_accepted=0 for any request that cycle.
  - Non-matching nonzero mem_data_tag is ignored.
- Load hit (no fill this cycle): accepted. Next cycle resp_valid=1 with the cached block. One-cycle latency.
- Load miss: accepted only if a free MSHR exists and no valid MSHR holds the same block address.
  - Lowest-index free MSHR allocated in WAIT_ISSUE with block address and req_tag.
  - No response until fill.
- Store, accepted only if all of:
  - no MSHR holds the same block address;
  - mem_resp_tag!=0 in the same cycle.
- Store drives: mem_command=STORE, mem_addr=block address, mem_wdata=block.
  - On hit, mem_wdata is the cached block with bytes req_size at offset merged in; cache updated.
  - On miss, mem_wdata is the merged bytes with other bytes 0; no allocate.
- Store response: next cycle resp_valid=1, resp_is_store=1, resp_data=0.
- Misaligned sizes (offset not multiple of size): undefined; bench must not drive.
- MSHR FSM: INVALID -> WAIT_ISSUE (alloc) -> WAIT_DATA (mem accepted, stores nonzero mem_resp_tag) -> INVALID (fill).
- Memory port arbitration, one command per cycle:
  - A store request owns the port.
  - Otherwise the oldest-allocated WAIT_ISSUE MSHR drives mem_command=LOAD.
  - If mem_resp_tag==0 the MSHR stays WAIT_ISSUE and retries next cycle.
  - An MSHR allocated this cycle issues no earlier than next cycle.
- Full: all MSHRs valid -> load misses rejected. Hits and stores are still served.
- resp_valid is a one-cycle pulse, with at most one response per cycle. The LSQ has no backpressure.
- Reset mid-operation: outstanding MSHRs dropped; late refills with old tags are ignored.

Optional Feature:
DCACHE_STATS_EN: adds outputs stat_hits, stat_misses, stat_rejects (32-bit each, reset 0, saturating).
- stat_hits: +1 per accepted load hit.
- stat_misses: +1 per MSHR allocation.
- stat_rejects: +1 per cycle with req_valid=1 and req_accepted=0.
Without it, the ports are absent and the behaviour is otherwise identical.

Test Plan:
1. Load 0x100 cold, mem_resp_tag=3, refill tag 3 with 0x1122334455667788 four cycles later -> one MSHR issue; response with data 0x1122334455667788 one cycle after the refill. A repeat load 0x104 then hits with 1-cycle latency and the same data.
2. Store word 0xDEADBEEF to 0x104 after test 1 -> mem STORE addr 0x100, wdata 0xDEADBEEF55667788. Response resp_is_store=1 next cycle; a load to 0x100 then returns the merged block.
3. Five load misses to distinct blocks, no refills -> first four accepted, fifth req_accepted=0. After one refill, a retry is accepted.
4. Load miss 0x200 pending, then a load or store to 0x208 and one to 0x204 -> 0x208 accepted, 0x204 rejected until the 0x200 refill.
5. Refill arrives in the same cycle as a hit request -> request rejected; refill response next cycle. The hit retried on the following cycle responds after that.
6. mem_resp_tag=0 for three cycles on an MSHR issue -> LOAD re-driven each cycle; transitions to WAIT_DATA on the first nonzero tag. Reset asserted mid-wait -> the late refill produces no response.
